bin_to_bcd_converter: RTL and testbench
=======================================

// Module: bin_to_bcd_converter
// PURPOSE
//  Sequential double-dabble converter: turns a binary count into packed BCD for decimal display.
//  Sits directly upstream of seven_seg_controller; bcd_out drives its 32-bit data_in.
//  One nibble per digit, digit 0 in bits [3:0].
//  Iterative: one shift per clock, start/busy/done handshake, result held until next conversion.
// PARAMETERS
//  BIN_W   27  width of bin_in; must satisfy 2^BIN_W > 10^DIGITS-1 headroom check below
//  DIGITS  8   BCD digits produced; bcd_out width = 4*DIGITS (32 at default)
// PORTS
//  clk      in   1         system clock, 100 MHz; all logic on posedge
//  rst      in   1         synchronous, active-high reset
//  start    in   1         request conversion of bin_in; sampled only when busy=0
//  bin_in   in   BIN_W     value to convert (unsigned; two's complement if SIGNED_EN)
//  busy     out  1         conversion in progress
//  done     out  1         one-cycle pulse: bcd_out/ovf/neg just updated
//  bcd_out  out  4*DIGITS  packed BCD result, held between conversions
//  ovf      out  1         last input exceeded 10^DIGITS-1
//  neg      out  1         last input was negative (SIGNED_EN only, else tied 0)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, bcd_out=0, ovf=0, neg=0. Takes effect on any cycle, mid-conversion
//   included. A conversion in flight is discarded with no done pulse.
//  FSM states:
//   IDLE: start=1 at edge k -> latch operand into shift reg, clear BCD scratch, bit_cnt=0, busy=1 at k+1 -> CONV.
//   CONV: each cycle, add 3 to every scratch nibble >=5, then shift {scratch,shift reg} left 1. bit_cnt++.
//  After BIN_W shifts (edge k+BIN_W) -> IDLE. Same edge: busy=0, done=1, bcd_out/ovf/neg registered.
//  Latency: start edge to done edge = BIN_W clocks (27 at default).
//  done is high for exactly one cycle. State is IDLE in that cycle, so a start there is accepted.
//   This gives back-to-back conversions every BIN_W+1 clocks.
//  start while busy=1: ignored, no queuing. bin_in is not sampled after accept.
//  Overflow: operand magnitude compared to 10^DIGITS-1 at accept; flag carried to done.
//   If set: bcd_out = all nibbles 4'h9, ovf=1. Else ovf=0 and bcd_out = exact BCD.
//  Scratch width 4*DIGITS + 4 guard bits so oversized inputs never corrupt the shifter.
//   Output is replaced by the saturate value when ovf=1.
//  bit_cnt width $clog2(BIN_W+1); no wrap within a conversion.
//  bcd_out nibbles are always 0-9, so the display never shows A-F.
// CONFIGURATION
//  SIGNED_EN defined: bin_in is two's complement.
//   At accept, the magnitude (negated if MSB=1) is loaded; neg = bin_in[BIN_W-1], registered at done.
//   The most negative value (-2^(BIN_W-1)) converts to its positive magnitude, e.g. 67108864.
//  SIGNED_EN undefined: bin_in unsigned, no negation logic, neg constant 0.
// TESTING
//  bin_in=0, start 1 cycle -> done exactly 27 clocks later; bcd_out=32'h00000000, ovf=0.
//  bin_in=12345678 -> bcd_out=32'h12345678. Then bin_in=99999999 -> 32'h99999999, ovf=0.
//  bin_in=100000000 -> bcd_out=32'h99999999, ovf=1. Next bin_in=5 -> 32'h00000005, ovf=0.
//  start re-pulsed with bin_in=42 at cycles 5 and 10 of a conversion of 777 -> single done, bcd_out=32'h00000777.
//  rst=1 at cycle 12 of a conversion -> next cycle busy=0, bcd_out=0, no done pulse.
//   Then start in the done cycle of 1 and 2 -> two done pulses 28 clocks apart.
//  SIGNED_EN: bin_in=-1 -> bcd_out=32'h00000001, neg=1. bin_in=-2^26 -> 32'h67108864, neg=1, ovf=0.

Source files
------------

// File: rtl/bin_to_bcd_converter_if.sv
// Handshake and result bundle between a binary producer and the BCD converter.
// The master side drives start/bin_in; the converter (slave) drives status and result.
interface bin_to_bcd_converter_if #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  ovf;
    logic                  neg;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  ovf,
        input  neg
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
        output ovf,
        output neg
    );
endinterface

// File: rtl/bin_to_bcd_converter.sv
// Iterative double-dabble binary-to-packed-BCD converter; SIGNED_EN selects two's-complement input with sign flag.
// Latency: BIN_W clocks from accepted start to the one-cycle done pulse; restartable in the done cycle.
// Backpressure: none queued; start is ignored while busy, result held until the next conversion ends.
module bin_to_bcd_converter #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    bin_to_bcd_converter_if.slave  bus
);
    localparam int SCR_W = 4*DIGITS + 4;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0]         MAX_VAL  = pow10(DIGITS) - 64'd1;
    localparam logic [4*DIGITS-1:0] ALL_NINE = {DIGITS{4'h9}};
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(BIN_W - 1);

    logic [0:0]          state_q,    state_d;
    logic [BIN_W-1:0]    shift_q,    shift_d;
    logic [SCR_W-1:0]    scratch_q,  scratch_d;
    logic [CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic [4*DIGITS-1:0] bcd_q,      bcd_d;
    logic                ovf_q,      ovf_d;
    logic                done_q,     done_d;

    logic [BIN_W-1:0]    operand_mag;
    logic [SCR_W-1:0]    scratch_adj;
    logic [SCR_W-1:0]    scratch_shl;
    logic [BIN_W-1:0]    shift_shl;

`ifdef SIGNED_EN
    logic                neg_pend_q, neg_pend_d;
    logic                neg_q,      neg_d;

    // -2^(BIN_W-1) negates to itself, which read unsigned is the wanted magnitude.
    assign operand_mag = bus.bin_in[BIN_W-1] ? (~bus.bin_in + 1'b1) : bus.bin_in;
`else
    assign operand_mag = bus.bin_in;
`endif

    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // The guard nibble absorbs the top bit of oversized operands; its carry-out drops off here.
    assign {scratch_shl, shift_shl} = {scratch_adj, shift_q} << 1;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        bit_cnt_d  = bit_cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
`ifdef SIGNED_EN
        neg_pend_d = neg_pend_q;
        neg_d      = neg_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    shift_d    = operand_mag;
                    scratch_d  = '0;
                    bit_cnt_d  = '0;
                    ovf_pend_d = (64'(operand_mag) > MAX_VAL);
`ifdef SIGNED_EN
                    neg_pend_d = bus.bin_in[BIN_W-1];
`endif
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                shift_d   = shift_shl;
                scratch_d = scratch_shl;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_CNT) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    bcd_d   = ovf_pend_q ? ALL_NINE : scratch_shl[4*DIGITS-1:0];
                    ovf_d   = ovf_pend_q;
`ifdef SIGNED_EN
                    neg_d   = neg_pend_q;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            bit_cnt_q  <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            bit_cnt_q  <= bit_cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

`ifdef SIGNED_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_pend_q <= 1'b0;
            neg_q      <= 1'b0;
        end else begin
            neg_pend_q <= neg_pend_d;
            neg_q      <= neg_d;
        end
    end

    assign bus.neg = neg_q;
`else
    assign bus.neg = 1'b0;
`endif

    assign bus.busy    = (state_q == ST_CONV);
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed self-checking bench: table of conversions run back-to-back, plus restart/reset corner sequences.
module tb_bin_to_bcd_converter;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    int   last_done_cyc;

    bin_to_bcd_converter_if #(.BIN_W(27), .DIGITS(8)) bus ();

    bin_to_bcd_converter #(.BIN_W(27), .DIGITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [26:0] bin;
        logic [31:0] bcd;
        logic        ovf;
        logic        neg;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Caller is positioned just after a rising edge; returns just after the done edge.
    task automatic start_and_wait(input logic [26:0] v, output int lat);
        bus.start  = 1'b1;
        bus.bin_in = v;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        chk("busy_after_accept", 64'(bus.busy), 64'd1);
        chk("done_low_after_accept", 64'(bus.done), 64'd0);
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        last_done_cyc = cyc;
    endtask

    initial begin
        int lat;
        int dones;
        int c1;
        logic [31:0] got_bcd;

        total = 0;
        bad   = 0;
        last_done_cyc = 0;

        vecs[0] = '{27'd0,        32'h00000000, 1'b0, 1'b0};
        vecs[1] = '{27'd12345678, 32'h12345678, 1'b0, 1'b0};
`ifdef SIGNED_EN
        vecs[2] = '{27'd99999999,  32'h34217729, 1'b0, 1'b1};
        vecs[3] = '{27'd100000000, 32'h34217728, 1'b0, 1'b1};
`else
        vecs[2] = '{27'd99999999,  32'h99999999, 1'b0, 1'b0};
        vecs[3] = '{27'd100000000, 32'h99999999, 1'b1, 1'b0};
`endif
        vecs[4] = '{27'd5,        32'h00000005, 1'b0, 1'b0};
        vecs[5] = '{27'd9,        32'h00000009, 1'b0, 1'b0};
        vecs[6] = '{27'd10,       32'h00000010, 1'b0, 1'b0};
        vecs[7] = '{27'd86400,    32'h00086400, 1'b0, 1'b0};
        vecs[8] = '{27'd10000000, 32'h10000000, 1'b0, 1'b0};
        vecs[9] = '{27'h3FFFFFF,  32'h67108863, 1'b0, 1'b0};
`ifdef SIGNED_EN
        vecs[10] = '{27'h7FFFFFF, 32'h00000001, 1'b0, 1'b1};
        vecs[11] = '{27'h4000000, 32'h67108864, 1'b0, 1'b1};
`else
        vecs[10] = '{27'h7FFFFFF, 32'h99999999, 1'b1, 1'b0};
        vecs[11] = '{27'h4000000, 32'h67108864, 1'b0, 1'b0};
`endif

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_bcd",  64'(bus.bcd_out), 64'd0);
        chk("reset_ovf",  64'(bus.ovf), 64'd0);
        chk("reset_neg",  64'(bus.neg), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Each conversion is started in the previous done cycle, so this also runs back-to-back.
        for (int i = 0; i < 12; i++) begin
            start_and_wait(vecs[i].bin, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd27);
            chk($sformatf("vec%0d_bcd", i), 64'(bus.bcd_out), 64'(vecs[i].bcd));
            chk($sformatf("vec%0d_ovf", i), 64'(bus.ovf), 64'(vecs[i].ovf));
            chk($sformatf("vec%0d_neg", i), 64'(bus.neg), 64'(vecs[i].neg));
            chk($sformatf("vec%0d_busy_at_done", i), 64'(bus.busy), 64'd0);
        end
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(bus.done), 64'd0);
        chk("result_held", 64'(bus.bcd_out), 64'(vecs[11].bcd));

        // Restart attempts with 42 during a conversion of 777 must be ignored.
        bus.start  = 1'b1;
        bus.bin_in = 27'd777;
        @(posedge clk); #1;
        dones   = 0;
        lat     = 0;
        got_bcd = '0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 5 || n == 10) begin
                bus.start  = 1'b1;
                bus.bin_in = 27'd42;
            end else begin
                bus.start  = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.done) begin
                dones++;
                lat     = n;
                got_bcd = bus.bcd_out;
            end
        end
        bus.start = 1'b0;
        chk("ignore_start_done_count", 64'(dones), 64'd1);
        chk("ignore_start_latency", 64'(lat), 64'd27);
        chk("ignore_start_bcd", 64'(got_bcd), 64'h777);

        // Reset in the middle of a conversion discards it without a done pulse.
        bus.start  = 1'b1;
        bus.bin_in = 27'd12345;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset_busy", 64'(bus.busy), 64'd0);
        chk("midreset_done", 64'(bus.done), 64'd0);
        chk("midreset_bcd",  64'(bus.bcd_out), 64'd0);
        chk("midreset_ovf",  64'(bus.ovf), 64'd0);
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        chk("midreset_no_done", 64'(dones), 64'd0);

        // Start accepted in the done cycle: pulses BIN_W+1 clocks apart.
        start_and_wait(27'd1, lat);
        chk("b2b_first_latency", 64'(lat), 64'd27);
        chk("b2b_first_bcd", 64'(bus.bcd_out), 64'h1);
        c1 = last_done_cyc;
        start_and_wait(27'd2, lat);
        chk("b2b_second_bcd", 64'(bus.bcd_out), 64'h2);
        chk("b2b_done_spacing", 64'(last_done_cyc - c1), 64'd28);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
